// File: rtl/buffer_config_pkg.sv
// Shared configuration for the framebuffer: geometry record, FSM states, depth helper.
package buffer_config_pkg;

  typedef struct packed {
    int width;
    int height;
    int addr_width;
    int data_width;
  } buffer_config_t;

  localparam buffer_config_t BUFFER_160x120x12 = '{
    width: 160, height: 120, addr_width: 15, data_width: 12
  };

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SWAP_WAIT
  } fb_state_t;

  // Words per bank.
  function automatic int fb_depth(buffer_config_t cfg);
    return cfg.width * cfg.height;
  endfunction

endpackage

// File: rtl/fb_bank.sv
// One pixel bank: single clock, one write port, one registered read port.
// Contents are deliberately not reset so the array maps onto block RAM.
module fb_bank #(
  parameter int DEPTH = 19200,
  parameter int AW    = 15,
  parameter int DW    = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write when enabled; read is always registered (1-cycle latency).
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/framebuffer_ctrl.sv
// Double-buffered framebuffer: Display reads the front bank, the renderer and the
// clear engine write the back bank, and swaps happen only on a vblank rising edge.
module framebuffer_ctrl
  import buffer_config_pkg::*;
#(
  parameter buffer_config_t BUFFER_CONFIG  = BUFFER_160x120x12,
  parameter bit             CLEAR_ON_RESET = 1'b0,
  localparam int AW = BUFFER_CONFIG.addr_width,
  localparam int DW = BUFFER_CONFIG.data_width
) (
  input  logic          clk_pixel,
  input  logic          rstn_pixel,
  input  logic [AW-1:0] read_addr,
  output logic [DW-1:0] read_data,
  input  logic          vblank,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [7:0]    wr_x,
  input  logic [7:0]    wr_y,
  input  logic [DW-1:0] wr_color,
  input  logic          clear_req,
  input  logic [DW-1:0] clear_color,
  output logic          clear_busy,
  input  logic          swap_req,
  output logic          swap_pending,
  output logic          front_sel
);

  localparam int            N          = fb_depth(BUFFER_CONFIG);
  localparam logic [AW:0]   N_EXT      = (AW+1)'(N);
  localparam logic [AW:0]   WIDTH_EXT  = (AW+1)'(BUFFER_CONFIG.width);
  localparam logic [AW:0]   HEIGHT_EXT = (AW+1)'(BUFFER_CONFIG.height);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(N - 1);

  fb_state_t     state_reg, state_next;
  logic [AW-1:0] count_reg, count_next;
  logic [DW-1:0] color_reg, color_next;
  logic          front_sel_reg, front_sel_next;
  logic          pending_reg, pending_next;
  logic [1:0]    init_left_reg, init_left_next;  // forced bank clears still owed after reset
  logic          run_reg;                        // low while in reset, high from the first cycle after
  logic          vblank_q;
  logic          vblank_rise;
  logic          clear_we;

  logic          rd_sel_reg;
  logic          rd_ok_reg;
  logic          rd_in_range;
  logic [DW-1:0] bank_rdata [2];

  logic [AW:0]   x_ext, y_ext, wr_lin;
  logic          wr_in_range;
  logic          wr_fire;
  logic          bank_we;
  logic [AW-1:0] bank_addr;
  logic [DW-1:0] bank_data;

  assign vblank_rise = vblank && !vblank_q;

  // State register and vblank edge history.
  always_ff @(posedge clk_pixel) begin
    if (!rstn_pixel) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      color_reg     <= '0;
      front_sel_reg <= 1'b0;
      pending_reg   <= 1'b0;
      init_left_reg <= CLEAR_ON_RESET ? 2'd2 : 2'd0;
      run_reg       <= 1'b0;
      vblank_q      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      color_reg     <= color_next;
      front_sel_reg <= front_sel_next;
      pending_reg   <= pending_next;
      init_left_reg <= init_left_next;
      run_reg       <= 1'b1;
      vblank_q      <= vblank;
    end
  end

  // Next-state logic and FSM outputs.
  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    color_next     = color_reg;
    front_sel_next = front_sel_reg;
    pending_next   = pending_reg;
    init_left_next = init_left_reg;
    clear_we       = 1'b0;
    clear_busy     = 1'b0;
    wr_ready       = 1'b0;
    unique case (state_reg)
      IDLE: begin
        wr_ready = run_reg && (init_left_reg == 2'd0);
        if (run_reg) begin
          if (init_left_reg != 2'd0 || clear_req) begin
            state_next = CLEAR;
            count_next = '0;
            color_next = (init_left_reg != 2'd0) ? '0 : clear_color;
            if (swap_req) pending_next = 1'b1;
          end else if (swap_req) begin
            state_next   = SWAP_WAIT;
            pending_next = 1'b1;
          end
        end
      end
      CLEAR: begin
        clear_we   = 1'b1;
        clear_busy = 1'b1;
        if (swap_req) pending_next = 1'b1;
        if (count_reg == LAST_ADDR) begin
          count_next = '0;
          if (init_left_reg == 2'd2) begin
            // Reset-time fill: flip banks immediately and clear the other one.
            front_sel_next = !front_sel_reg;
            init_left_next = 2'd1;
          end else begin
            init_left_next = 2'd0;
            state_next     = (pending_reg || swap_req) ? SWAP_WAIT : IDLE;
          end
        end else begin
          count_next = count_reg + 1'b1;
        end
      end
      SWAP_WAIT: begin
        if (vblank_rise) begin
          front_sel_next = !front_sel_reg;
          pending_next   = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign swap_pending = pending_reg;
  assign front_sel    = front_sel_reg;

  // Pixel address is formed one bit wider than the bank so off-screen
  // coordinates can never alias onto a valid word.
  assign x_ext       = (AW+1)'(wr_x);
  assign y_ext       = (AW+1)'(wr_y);
  assign wr_lin      = y_ext * WIDTH_EXT + x_ext;
  assign wr_in_range = (x_ext < WIDTH_EXT) && (y_ext < HEIGHT_EXT) && (wr_lin < N_EXT);
  assign wr_fire     = wr_valid && wr_ready;
  assign bank_we     = rstn_pixel && (clear_we || (wr_fire && wr_in_range));
  assign bank_addr   = clear_we ? count_reg : wr_lin[AW-1:0];
  assign bank_data   = clear_we ? color_reg : wr_color;

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    fb_bank #(
      .DEPTH (N),
      .AW    (AW),
      .DW    (DW)
    ) u_bank (
      .clk   (clk_pixel),
      .we    (bank_we && (front_sel_reg != 1'(gi))),
      .waddr (bank_addr),
      .wdata (bank_data),
      .raddr (read_addr),
      .rdata (bank_rdata[gi])
    );
  end

  assign rd_in_range = {1'b0, read_addr} < N_EXT;

  // Remember which bank and whether the address was valid in the address cycle.
  always_ff @(posedge clk_pixel) begin
    if (!rstn_pixel) begin
      rd_sel_reg <= 1'b0;
      rd_ok_reg  <= 1'b0;
    end else begin
      rd_sel_reg <= front_sel_reg;
      rd_ok_reg  <= rd_in_range;
    end
  end

  assign read_data = !rd_ok_reg ? '0 : (rd_sel_reg ? bank_rdata[1] : bank_rdata[0]);

endmodule

// File: tb/tb_framebuffer_ctrl.sv
// Directed bench for framebuffer_ctrl: write/read vector tables plus hand sequences
// for clear, swap timing and reset-abort corner cases, with a two-bank model.
module tb_framebuffer_ctrl;

  localparam int N = 19200;

  logic        clk_pixel = 1'b0;
  logic        rstn_pixel;
  logic [14:0] read_addr;
  logic [11:0] read_data;
  logic        vblank;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_x;
  logic [7:0]  wr_y;
  logic [11:0] wr_color;
  logic        clear_req;
  logic [11:0] clear_color;
  logic        clear_busy;
  logic        swap_req;
  logic        swap_pending;
  logic        front_sel;

  int checks   = 0;
  int failures = 0;

  logic [11:0] m0 [N];
  logic [11:0] m1 [N];

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [11:0] color;
    bit          ok;
    int          addr;
  } wr_vec_t;

  typedef struct {
    logic [14:0] addr;
    logic [11:0] data;
  } rd_vec_t;

  wr_vec_t wv [8];
  rd_vec_t rv [10];

  framebuffer_ctrl dut (
    .clk_pixel    (clk_pixel),
    .rstn_pixel   (rstn_pixel),
    .read_addr    (read_addr),
    .read_data    (read_data),
    .vblank       (vblank),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_x         (wr_x),
    .wr_y         (wr_y),
    .wr_color     (wr_color),
    .clear_req    (clear_req),
    .clear_color  (clear_color),
    .clear_busy   (clear_busy),
    .swap_req     (swap_req),
    .swap_pending (swap_pending),
    .front_sel    (front_sel)
  );

  always #5 clk_pixel = !clk_pixel;

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs until clear_busy drops (bounded); reports busy cycles and side observations.
  task automatic run_clear(output int busy, output int ready_hi, output int pend_hi);
    busy = 0;
    ready_hi = 0;
    pend_hi = 0;
    while (clear_busy && busy < 20000) begin
      if (wr_ready) ready_hi++;
      if (swap_pending) pend_hi++;
      busy++;
      tick();
    end
  endtask

  task automatic compare_banks(input string name);
    int bad;
    int idx;
    int bnk;
    logic [11:0] got;
    logic [11:0] want;
    bad = 0; idx = -1; bnk = 0; got = '0; want = '0;
    for (int i = 0; i < N; i++) begin
      if (dut.g_bank[0].u_bank.mem[i] !== m0[i]) begin
        if (bad == 0) begin idx = i; bnk = 0; got = dut.g_bank[0].u_bank.mem[i]; want = m0[i]; end
        bad++;
      end
      if (dut.g_bank[1].u_bank.mem[i] !== m1[i]) begin
        if (bad == 0) begin idx = i; bnk = 1; got = dut.g_bank[1].u_bank.mem[i]; want = m1[i]; end
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s: %0d words differ, bank%0d[%0d] got 0x%03h expected 0x%03h",
               name, bad, bnk, idx, got, want);
    end
  endtask

  initial begin
    int busy, rhi, phi;

    wv[0] = '{8'd3,   8'd2,   12'hABC, 1'b1, 323};
    wv[1] = '{8'd0,   8'd0,   12'h123, 1'b1, 0};
    wv[2] = '{8'd159, 8'd119, 12'hFED, 1'b1, 19199};
    wv[3] = '{8'd0,   8'd1,   12'h456, 1'b1, 160};
    wv[4] = '{8'd160, 8'd5,   12'h777, 1'b0, 0};
    wv[5] = '{8'd5,   8'd120, 12'h888, 1'b0, 0};
    wv[6] = '{8'd255, 8'd255, 12'h999, 1'b0, 0};
    wv[7] = '{8'd159, 8'd0,   12'h246, 1'b1, 159};

    rv[0] = '{15'd323,   12'hABC};
    rv[1] = '{15'd0,     12'h123};
    rv[2] = '{15'd19199, 12'hFED};
    rv[3] = '{15'd160,   12'h456};
    rv[4] = '{15'd159,   12'h246};
    rv[5] = '{15'd8287,  12'h111};
    rv[6] = '{15'd960,   12'h111};
    rv[7] = '{15'd1,     12'h111};
    rv[8] = '{15'd19200, 12'h000};
    rv[9] = '{15'd32767, 12'h000};

    rstn_pixel = 1'b0; read_addr = '0; vblank = 1'b0; wr_valid = 1'b0;
    wr_x = '0; wr_y = '0; wr_color = '0; clear_req = 1'b0; clear_color = '0; swap_req = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_front_sel", 32'(front_sel), 32'd0);
    check("rst_read_data", 32'(read_data), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_clear_busy", 32'(clear_busy), 32'd0);
    check("rst_swap_pending", 32'(swap_pending), 32'd0);
    rstn_pixel = 1'b1;
    tick();
    check("ready_after_reset", 32'(wr_ready), 32'd1);

    // Clear and swap requested together: clear bank1, then swap on vblank edge
    clear_color = 12'h111; clear_req = 1'b1; swap_req = 1'b1;
    tick();
    clear_req = 1'b0; swap_req = 1'b0;
    run_clear(busy, rhi, phi);
    $display("clear+swap color=111 busy=%0d", busy);
    check("cs_busy_cycles", 32'(busy), 32'd19200);
    check("cs_ready_during", 32'(rhi), 32'd0);
    check("cs_pending_during", 32'(phi), 32'd19200);
    for (int i = 0; i < N; i++) m1[i] = 12'h111;
    check("cs_pending_wait", 32'(swap_pending), 32'd1);
    tick(); tick();
    check("cs_front_held", 32'(front_sel), 32'd0);
    check("cs_ready_frozen", 32'(wr_ready), 32'd0);
    vblank = 1'b1;
    tick();
    check("cs_front_toggled", 32'(front_sel), 32'd1);
    check("cs_pending_clr", 32'(swap_pending), 32'd0);
    check("cs_ready_back", 32'(wr_ready), 32'd1);

    // Plain clear of back bank0 with 0x0F0
    clear_color = 12'h0F0; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    run_clear(busy, rhi, phi);
    $display("clear color=0f0 busy=%0d", busy);
    check("clr_busy_cycles", 32'(busy), 32'd19200);
    check("clr_ready_during", 32'(rhi), 32'd0);
    check("clr_no_pending", 32'(phi), 32'd0);
    for (int i = 0; i < N; i++) m0[i] = 12'h0F0;
    compare_banks("clr_banks");

    // Swap requested while vblank is already high
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    check("vbh_pending", 32'(swap_pending), 32'd1);
    repeat (3) tick();
    check("vbh_no_toggle", 32'(front_sel), 32'd1);
    check("vbh_ready_frozen", 32'(wr_ready), 32'd0);
    vblank = 1'b0;
    tick();
    check("vbh_low_no_toggle", 32'(front_sel), 32'd1);
    vblank = 1'b1;
    tick();
    check("vbh_toggle", 32'(front_sel), 32'd0);
    check("vbh_pending_clr", 32'(swap_pending), 32'd0);

    // Write vectors into back bank1 (front_sel = 0)
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_x = wv[i].x; wr_y = wv[i].y; wr_color = wv[i].color;
      $display("write x=%0d y=%0d color=%03h ready=%0b", wv[i].x, wv[i].y, wv[i].color, wr_ready);
      check("wr_ready_vec", 32'(wr_ready), 32'd1);
      tick();
      wr_valid = 1'b0;
      if (wv[i].ok) m1[wv[i].addr] = wv[i].color;
    end
    compare_banks("wr_banks");

    // Swap so bank1 becomes front, then read it back
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0; vblank = 1'b0;
    tick();
    vblank = 1'b1;
    tick();
    check("rd_front_sel", 32'(front_sel), 32'd1);
    for (int i = 0; i < 10; i++) begin
      read_addr = rv[i].addr;
      tick();
      $display("read addr=%0d data=%03h", rv[i].addr, read_data);
      check("rd_vec", 32'(read_data), 32'(rv[i].data));
    end

    // Reset after 100 clear writes to back bank0, with a swap requested mid-clear
    clear_color = 12'h5A5; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (k == 10) swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
    end
    check("abort_busy_before", 32'(clear_busy), 32'd1);
    check("abort_pending_before", 32'(swap_pending), 32'd1);
    rstn_pixel = 1'b0;
    tick();
    check("abort_front_sel", 32'(front_sel), 32'd0);
    check("abort_read_data", 32'(read_data), 32'd0);
    check("abort_wr_ready", 32'(wr_ready), 32'd0);
    check("abort_clear_busy", 32'(clear_busy), 32'd0);
    check("abort_swap_pending", 32'(swap_pending), 32'd0);
    for (int i = 0; i < 100; i++) m0[i] = 12'h5A5;
    compare_banks("abort_banks");
    rstn_pixel = 1'b1;
    tick();
    check("abort_ready_after", 32'(wr_ready), 32'd1);
    read_addr = 15'd50;    tick(); check("abort_rd_50", 32'(read_data), 32'h5A5);
    read_addr = 15'd99;    tick(); check("abort_rd_99", 32'(read_data), 32'h5A5);
    read_addr = 15'd100;   tick(); check("abort_rd_100", 32'(read_data), 32'h0F0);
    read_addr = 15'd19200; tick(); check("abort_rd_oob", 32'(read_data), 32'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
